// File: rtl/store_merge_rmw_pkg.sv
// -----------------------------------------------------------------------------
// store_merge_rmw_pkg
//
// Shared definitions for the store byte-lane merge unit:
//   - store size encodings (SZ_BYTE / SZ_HALF / SZ_WORD / SZ_RSVD)
//   - lane count and word width
//   - FSM state encoding (also visible on the debug state port of the top)
//   - expand_lanes(): turns a per-byte lane mask into a per-bit mask
// -----------------------------------------------------------------------------
package store_merge_rmw_pkg;

    // Memory word geometry. The unit only supports 32-bit words with 4 byte lanes.
    localparam int WORD_W = 32;
    localparam int LANES  = 4;

    // Store size encodings as presented on req_size.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // FSM states.
    //   ST_IDLE  : ready for a new request
    //   ST_READ  : RAM read strobe issued for the target word
    //   ST_WAIT  : RAM data arrives, merged word is captured
    //   ST_WRITE : merged (or full) word written back, done pulse
    //   ST_ERR   : misaligned/reserved request dropped, err pulse
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_ERR   = 3'd4
    } state_e;

    // Expand each lane-mask bit into a full byte of bit-mask.
    function automatic logic [WORD_W-1:0] expand_lanes(input logic [LANES-1:0] lane_mask);
        logic [WORD_W-1:0] bits;
        bits = '0;
        for (int i = 0; i < LANES; i++) begin
            bits[8*i +: 8] = {8{lane_mask[i]}};
        end
        return bits;
    endfunction

endpackage

// File: rtl/store_merge_rmw_lane_mask.sv
// -----------------------------------------------------------------------------
// store_merge_rmw_lane_mask
//
// Purely combinational decode of a store request into its byte-lane mask and
// an alignment verdict.
//
// Ports
//   size_i        in   2   store size (SZ_BYTE / SZ_HALF / SZ_WORD / SZ_RSVD)
//   lane_i        in   2   byte lane = low two bits of the byte address
//   mask_o        out  4   lanes touched by the store (bit n = byte n)
//   misaligned_o  out  1   request cannot be performed and must be dropped
// -----------------------------------------------------------------------------
module store_merge_rmw_lane_mask
    import store_merge_rmw_pkg::*;
(
    input  logic [1:0]       size_i,
    input  logic [1:0]       lane_i,
    output logic [LANES-1:0] mask_o,
    output logic             misaligned_o
);

    always_comb begin
        mask_o       = '0;
        misaligned_o = 1'b0;
        case (size_i)
            SZ_BYTE: begin
                mask_o = 4'b0001 << lane_i;
            end
            SZ_HALF: begin
                // A half on an odd byte would straddle lanes 1/2 or run off lane 3.
                mask_o       = 4'b0011 << lane_i;
                misaligned_o = lane_i[0];
            end
            SZ_WORD: begin
                mask_o       = 4'b1111;
                misaligned_o = (lane_i != 2'b00);
            end
            default: begin
                // Reserved size is handled exactly like a misaligned request.
                mask_o       = '0;
                misaligned_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/store_merge_rmw.sv
// -----------------------------------------------------------------------------
// store_merge_rmw
//
// Write-side byte-lane merge unit between the CPU store path and a synchronous
// data RAM. Full-word stores are written directly; byte and half stores run a
// read-modify-write: read the word, clear the target lanes, OR in the shifted
// store data and write it back. Misaligned or reserved-size requests are
// dropped with a one-cycle err pulse and never touch the RAM.
//
// Ports
//   clk_i          in   1         clock, rising edge
//   rst_i          in   1         asynchronous, active-high reset
//   req_valid_i    in   1         store request valid
//   req_ready_o    out  1         unit idle and able to accept
//   req_addr_i     in   ADDR_W    byte address
//   req_data_i     in   32        store data, right-aligned
//   req_size_i     in   2         00 byte, 01 half, 10 word, 11 reserved
//   mem_addr_o     out  ADDR_W-2  RAM word address
//   mem_rd_en_o    out  1         RAM read strobe (data returns next cycle)
//   mem_rd_data_i  in   32        RAM read data
//   mem_wr_en_o    out  1         RAM full-word write strobe
//   mem_wr_data_o  out  32        merged word to write
//   done_o         out  1         one-cycle pulse: store committed
//   err_o          out  1         one-cycle pulse: request dropped
//   state_o        out  3         current FSM state (debug)
//
// Handshake: a request is accepted on a rising edge where req_valid_i and
// req_ready_o are both 1. req_ready_o is 1 only in IDLE; a requester seeing
// ready low holds its request. All request fields are latched at acceptance
// and may change afterwards.
//
// Timing, T = accept cycle:
//   word     : T+1 write + done,                 ready again at T+2
//   sub-word : T+1 read, T+2 capture, T+3 write, ready again at T+4
//   error    : T+1 err,                          ready again at T+2
// -----------------------------------------------------------------------------
module store_merge_rmw
    import store_merge_rmw_pkg::*;
#(
    parameter int DATA_W = 32,  // fixed: the lane logic assumes 4 byte lanes
    parameter int ADDR_W = 12
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_data_i,
    input  logic [1:0]        req_size_i,
    output logic [ADDR_W-3:0] mem_addr_o,
    output logic              mem_rd_en_o,
    input  logic [DATA_W-1:0] mem_rd_data_i,
    output logic              mem_wr_en_o,
    output logic [DATA_W-1:0] mem_wr_data_o,
    output logic              done_o,
    output logic              err_o,
    output logic [2:0]        state_o
);

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    state_e             state_q, state_d;

    // Request latch
    logic [ADDR_W-1:0]  addr_q,  addr_d;
    logic [DATA_W-1:0]  data_q,  data_d;
    logic [LANES-1:0]   mask_q,  mask_d;

    // Output registers; merge_q doubles as the merge register feeding the write.
    logic               ready_q, ready_d;
    logic [ADDR_W-3:0]  maddr_q, maddr_d;
    logic               rd_en_q, rd_en_d;
    logic               wr_en_q, wr_en_d;
    logic [DATA_W-1:0]  merge_q, merge_d;
    logic               done_q,  done_d;
    logic               err_q,   err_d;

    logic               accept;
    logic [LANES-1:0]   req_mask;
    logic               req_misaligned;
    logic [1:0]         lane_q;
    logic [DATA_W-1:0]  lane_bits;
    logic [DATA_W-1:0]  shifted;
    logic [DATA_W-1:0]  merged;

    // -------------------------------------------------------------------------
    // Request decode
    // -------------------------------------------------------------------------
    store_merge_rmw_lane_mask u_lane_mask (
        .size_i       (req_size_i),
        .lane_i       (req_addr_i[1:0]),
        .mask_o       (req_mask),
        .misaligned_o (req_misaligned)
    );

    // ready_q is only ever 1 while the FSM sits in IDLE.
    assign accept = req_valid_i & ready_q;

    // -------------------------------------------------------------------------
    // Merge datapath: keep the untouched lanes of the RAM word, replace the
    // target lanes with the store data moved up to its lane. Store data bits
    // above the store size fall outside the lane mask and are discarded.
    // -------------------------------------------------------------------------
    assign lane_q    = addr_q[1:0];
    assign lane_bits = expand_lanes(mask_q);
    assign shifted   = data_q << {lane_q, 3'b000};
    assign merged    = (mem_rd_data_i & ~lane_bits) | (shifted & lane_bits);

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            mask_q  <= '0;
            ready_q <= 1'b0;
            maddr_q <= '0;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            merge_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            ready_q <= ready_d;
            maddr_q <= maddr_d;
            rd_en_q <= rd_en_d;
            wr_en_q <= wr_en_d;
            merge_q <= merge_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_misaligned) begin
                        state_d = ST_ERR;
                    end else if (req_size_i == SZ_WORD) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ:  state_d = ST_WAIT;
            ST_WAIT:  state_d = ST_WRITE;
            ST_WRITE: state_d = ST_IDLE;
            ST_ERR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Request latch: captured only on acceptance, held otherwise.
    // -------------------------------------------------------------------------
    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        mask_d = mask_q;
        if (accept) begin
            addr_d = req_addr_i;
            data_d = req_data_i;
            mask_d = req_mask;
        end
    end

    // -------------------------------------------------------------------------
    // Output logic. Outputs are registered, so their next values are decoded
    // from the next state; that way each strobe is high exactly during the
    // cycle the FSM spends in the matching state.
    // -------------------------------------------------------------------------
    always_comb begin
        ready_d = (state_d == ST_IDLE);
        rd_en_d = (state_d == ST_READ);
        wr_en_d = (state_d == ST_WRITE);
        done_d  = (state_d == ST_WRITE);
        err_d   = (state_d == ST_ERR);

        // Word address is driven from READ through WRITE, zero otherwise.
        // On the accept edge the latch is not loaded yet, so take it from
        // the request directly.
        maddr_d = '0;
        if ((state_d == ST_READ) || (state_d == ST_WAIT) || (state_d == ST_WRITE)) begin
            if (state_q == ST_IDLE) begin
                maddr_d = req_addr_i[ADDR_W-1:2];
            end else begin
                maddr_d = addr_q[ADDR_W-1:2];
            end
        end

        // Write data: full word straight from the request, or the merge of
        // the RAM word returned during WAIT.
        merge_d = '0;
        if (state_d == ST_WRITE) begin
            if (state_q == ST_IDLE) begin
                merge_d = req_data_i;
            end else begin
                merge_d = merged;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Port drive
    // -------------------------------------------------------------------------
    assign req_ready_o   = ready_q;
    assign mem_addr_o    = maddr_q;
    assign mem_rd_en_o   = rd_en_q;
    assign mem_wr_en_o   = wr_en_q;
    assign mem_wr_data_o = merge_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_store_merge_rmw.sv
// -----------------------------------------------------------------------------
// tb_store_merge_rmw
//
// Bench for store_merge_rmw. A synchronous RAM model answers the DUT; a
// byte-addressed reference memory holds what the RAM should contain after
// each store, so expected write data is derived from byte-level store rules.
// -----------------------------------------------------------------------------
module tb_store_merge_rmw;
    import store_merge_rmw_pkg::*;

    // -------------------------------------------------------------------------
    // Clock / reset
    // -------------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // DUT signals
    // -------------------------------------------------------------------------
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [11:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [1:0]  req_size = '0;
    logic [9:0]  mem_addr;
    logic        mem_rd_en;
    logic [31:0] mem_rd_data = '0;
    logic        mem_wr_en;
    logic [31:0] mem_wr_data;
    logic        done;
    logic        err;
    logic [2:0]  dbg_state;

    store_merge_rmw #(
        .DATA_W (32),
        .ADDR_W (12)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_addr_i    (req_addr),
        .req_data_i    (req_data),
        .req_size_i    (req_size),
        .mem_addr_o    (mem_addr),
        .mem_rd_en_o   (mem_rd_en),
        .mem_rd_data_i (mem_rd_data),
        .mem_wr_en_o   (mem_wr_en),
        .mem_wr_data_o (mem_wr_data),
        .done_o        (done),
        .err_o         (err),
        .state_o       (dbg_state)
    );

    // -------------------------------------------------------------------------
    // RAM model (synchronous read, one-cycle latency) and reference memory
    // -------------------------------------------------------------------------
    logic [31:0] ram     [0:1023];
    logic [7:0]  ref_mem [0:4095];

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= ram[mem_addr];
        if (mem_wr_en) ram[mem_addr] <= mem_wr_data;
    end

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int last_acc = -1;
    int gap = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // -------------------------------------------------------------------------
    // Checker
    // -------------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Read and write strobes must never overlap.
    always @(negedge clk) begin
        if (!rst) check("rd_wr_exclusive", {31'b0, mem_rd_en & mem_wr_en}, 32'd0);
    end

    function automatic logic [31:0] ref_word(input int w);
        return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
    endfunction

    task automatic set_word(input int w, input logic [31:0] v);
        ram[w] = v;
        for (int i = 0; i < 4; i++) ref_mem[4*w+i] = v[8*i +: 8];
    endtask

    function automatic logic [4:0] strobes();
        return {req_ready, mem_rd_en, mem_wr_en, done, err};
    endfunction

    // -------------------------------------------------------------------------
    // Driver: issue one store starting at a negedge, follow it cycle by cycle
    // and return at the negedge where ready is expected back.
    // -------------------------------------------------------------------------
    task automatic do_store(input logic [11:0] addr, input logic [31:0] data,
                            input logic [1:0] size, input bit hold);
        int n;
        int nb;
        bit mis;
        logic [31:0] exp_word;
        logic [9:0] wa;

        req_addr  = addr;
        req_data  = data;
        req_size  = size;
        req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) begin
            check("ready_timeout", {31'b0, req_ready}, 32'd1);
            req_valid = 1'b0;
            return;
        end
        if (last_acc >= 0) gap = cyc - last_acc;
        last_acc = cyc;

        // Reference: a store of nb bytes writes data bytes little-endian at
        // addr..addr+nb-1, and is legal only when addr is a multiple of nb.
        nb  = 1 << size;
        mis = (size == SZ_RSVD) || ((int'(addr) % nb) != 0);
        wa  = addr[11:2];
        exp_word = '0;
        if (!mis) begin
            for (int i = 0; i < nb; i++) ref_mem[int'(addr) + i] = data[8*i +: 8];
            exp_word = ref_word(int'(wa));
        end

        @(negedge clk);  // T+1
        if (!hold) req_valid = 1'b0;
        // The request was latched at acceptance; these must have no effect.
        req_addr = 12'($urandom);
        req_data = $urandom;
        req_size = 2'($urandom);

        if (mis) begin
            check("err_t1_strobes", {27'b0, strobes()}, 32'b00001);
            check("err_t1_addr", {22'b0, mem_addr}, 32'd0);
            @(negedge clk);
            check("err_t2_strobes", {27'b0, strobes()}, 32'b10000);
        end else if (size == SZ_WORD) begin
            check("sw_t1_strobes", {27'b0, strobes()}, 32'b00110);
            check("sw_t1_addr", {22'b0, mem_addr}, {22'b0, wa});
            check("sw_t1_data", mem_wr_data, exp_word);
            @(negedge clk);
            check("sw_t2_strobes", {27'b0, strobes()}, 32'b10000);
        end else begin
            check("rmw_t1_strobes", {27'b0, strobes()}, 32'b01000);
            check("rmw_t1_addr", {22'b0, mem_addr}, {22'b0, wa});
            @(negedge clk);
            check("rmw_t2_strobes", {27'b0, strobes()}, 32'b00000);
            check("rmw_t2_addr", {22'b0, mem_addr}, {22'b0, wa});
            @(negedge clk);
            check("rmw_t3_strobes", {27'b0, strobes()}, 32'b00110);
            check("rmw_t3_addr", {22'b0, mem_addr}, {22'b0, wa});
            check("rmw_t3_data", mem_wr_data, exp_word);
            @(negedge clk);
            check("rmw_t4_strobes", {27'b0, strobes()}, 32'b10000);
            check("rmw_t4_addr", {22'b0, mem_addr}, 32'd0);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'b0, req_ready}, 32'd1);
    endtask

    // -------------------------------------------------------------------------
    // Watchdog
    // -------------------------------------------------------------------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        for (int w = 0; w < 1024; w++) set_word(w, $urandom);

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_strobes", {27'b0, strobes()}, 32'd0);
        check("rst_addr", {22'b0, mem_addr}, 32'd0);
        check("rst_wdata", mem_wr_data, 32'd0);
        check("rst_state", {29'b0, dbg_state}, {29'b0, ST_IDLE});
        rst = 1'b0;
        wait_ready("ready_after_rst");

        // 1: aligned word, no read
        do_store(12'h010, 32'hDEADBEEF, SZ_WORD, 1'b0);
        check("t1_ram", ram[4], 32'hDEADBEEF);

        // 2: byte into lane 2
        set_word(4, 32'h11223344);
        do_store(12'h012, 32'h000000AA, SZ_BYTE, 1'b0);
        check("t2_ram", ram[4], 32'h11AA3344);

        // 3: halves
        set_word(0, 32'h11223344);
        do_store(12'h002, 32'h0000BEEF, SZ_HALF, 1'b0);
        check("t3a_ram", ram[0], 32'hBEEF3344);
        set_word(0, 32'h11223344);
        do_store(12'h000, 32'h0000BEEF, SZ_HALF, 1'b0);
        check("t3b_ram", ram[0], 32'h1122BEEF);

        // 4: misaligned / reserved, RAM untouched
        set_word(2, 32'h0BADF00D);
        do_store(12'h001, 32'h12345678, SZ_HALF, 1'b0);
        do_store(12'h006, 32'h12345678, SZ_WORD, 1'b0);
        do_store(12'h008, 32'h12345678, SZ_RSVD, 1'b0);
        check("t4_ram", ram[2], 32'h0BADF00D);

        // 5: reset during WAIT aborts the store
        set_word(32, 32'hCAFEF00D);
        req_addr  = 12'h081;
        req_data  = 32'h00000055;
        req_size  = SZ_BYTE;
        req_valid = 1'b1;
        @(negedge clk);  // T+1 (READ)
        req_valid = 1'b0;
        @(negedge clk);  // T+2 (WAIT)
        #1 rst = 1'b1;
        #1;
        check("t5_rst_strobes", {27'b0, strobes()}, 32'd0);
        check("t5_rst_addr", {22'b0, mem_addr}, 32'd0);
        check("t5_rst_wdata", mem_wr_data, 32'd0);
        repeat (3) @(negedge clk);
        check("t5_rst_hold", {27'b0, strobes()}, 32'd0);
        rst = 1'b0;
        wait_ready("t5_ready");
        check("t5_no_write", ram[32], ref_word(32));
        do_store(12'h081, 32'h00000055, SZ_BYTE, 1'b0);
        check("t5_after", ram[32], 32'hCAFE550D);

        // 6: back-to-back bytes with valid held
        set_word(3, 32'h11223344);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] bval;
            bval = 32'hFFFFFF00 | (32'hAA + 32'(i) * 32'h11);
            do_store(12'h00C + 12'(i), bval, SZ_BYTE, 1'b1);
            if (i > 0) check("t6_gap", 32'(gap), 32'd4);
        end
        req_valid = 1'b0;
        check("t6_final", ram[3], 32'hDDCCBBAA);

        // Randomized stores over a small window to force overlaps.
        for (int k = 0; k < 250; k++) begin
            logic [11:0] a;
            logic [1:0]  s;
            bit          h;
            a = 12'($urandom_range(0, 127));
            s = 2'($urandom_range(0, 3));
            h = ($urandom_range(0, 3) == 0);
            do_store(a, $urandom, s, h);
            if (!h) begin
                req_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        req_valid = 1'b0;
        repeat (3) @(negedge clk);

        for (int w = 0; w < 32; w++) check("final_ram", ram[w], ref_word(w));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
